// File: rtl/uart_pkg.sv
// Shared UART constants and elaboration-time helpers.
// Consumed by the receive FIFO and its storage array.
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int FIFO_DEPTH_DEF    = 16;
  localparam int FIFO_AFULL_TH_DEF = 12;

  // Ceiling log2 for parameter arithmetic; clog2(1) returns 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (rem > 0) begin
        result = result + 1;
        rem    = rem >> 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the receive FIFO.
// Synchronous write port and combinational read port; contents are not reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH_DEF,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [UART_DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0]      raddr,
  output logic [UART_DATA_W-1:0] rdata
);

  logic [UART_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART receiver and the core: show-ahead read
// port, occupancy/almost-full/full reporting and a sticky overflow flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH    = FIFO_DEPTH_DEF,
  parameter int ADDR_W   = clog2(DEPTH),
  parameter int AFULL_TH = FIFO_AFULL_TH_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wr_en,
  input  logic [UART_DATA_W-1:0] i_wr_data,
  input  logic                   i_flush,
  output logic [UART_DATA_W-1:0] o_rd_data,
  output logic                   o_rd_valid,
  input  logic                   i_rd_ready,
  output logic [ADDR_W:0]        o_count,
  output logic                   o_afull,
  output logic                   o_full,
  output logic                   o_ovf,
  input  logic                   i_ovf_clr
);

  localparam int PTR_W = ADDR_W + 1;
  localparam logic [ADDR_W:0] PTR_ONE   = PTR_W'(1);
  localparam logic [ADDR_W:0] DEPTH_CNT = PTR_W'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_CNT = PTR_W'(AFULL_TH);

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] count;
  logic [ADDR_W:0] count_nxt;
  logic            full;
  logic            afull;
  logic            ovf;
  logic            ovf_nxt;
  logic            empty;
  logic            pop;
  logic            push;
  logic            ovf_set;
  logic            mem_we;

  assign empty = (wr_ptr == rd_ptr);

  // A pop frees a slot in the same edge, so a full FIFO still accepts a push
  // when the consumer is reading.
  assign pop     = !empty && i_rd_ready;
  assign push    = i_wr_en && (!full || pop);
  assign ovf_set = i_wr_en && full && !pop;
  assign mem_we  = push && !i_flush;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + PTR_ONE;
      2'b01:   count_nxt = count - PTR_ONE;
      default: count_nxt = count;
    endcase
  end

  // Set beats clear when both happen on the same edge.
  assign ovf_nxt = ovf_set || (ovf && !i_ovf_clr);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      afull  <= 1'b0;
      ovf    <= 1'b0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      afull  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_CNT);
      afull <= (count_nxt >= AFULL_CNT);
      ovf   <= ovf_nxt;
    end
  end

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (i_clk),
    .we    (mem_we),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (i_wr_data),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (o_rd_data)
  );

  assign o_rd_valid = !empty;
  assign o_count    = count;
  assign o_full     = full;
  assign o_afull    = afull;
  assign o_ovf      = ovf;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench for uart_rx_fifo, checked against a
// queue-based model of the FIFO's observable behaviour.
module tb_uart_rx_fifo;

  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 4;
  localparam int AFULL_TH = 12;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b1;
  logic              wr_en    = 1'b0;
  logic [7:0]        wr_data  = 8'h00;
  logic              flush    = 1'b0;
  logic              rd_ready = 1'b0;
  logic              ovf_clr  = 1'b0;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic [ADDR_W:0]   count;
  logic              afull;
  logic              full;
  logic              ovf;

  int checks = 0;
  int errors = 0;
  string phase = "reset";

  byte unsigned q[$];
  bit           m_ovf = 1'b0;

  uart_rx_fifo #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .AFULL_TH (AFULL_TH)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_wr_en    (wr_en),
    .i_wr_data  (wr_data),
    .i_flush    (flush),
    .o_rd_data  (rd_data),
    .o_rd_valid (rd_valid),
    .i_rd_ready (rd_ready),
    .o_count    (count),
    .o_afull    (afull),
    .o_full     (full),
    .o_ovf      (ovf),
    .i_ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s.%s: observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check("valid", 32'(rd_valid), 32'(n > 0));
    if (n > 0) check("data", 32'(rd_data), 32'(q[0]));
    check("count", 32'(count), 32'(n));
    check("full", 32'(full), 32'(n == DEPTH));
    check("afull", 32'(afull), 32'(n >= AFULL_TH));
    check("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  // One clock: drive inputs, apply the edge to the model, then compare.
  task automatic step(input bit wr, input byte unsigned d, input bit rdy,
                      input bit fl, input bit clr);
    bit do_pop;
    bit drop;
    wr_en    = wr;
    wr_data  = d;
    rd_ready = rdy;
    flush    = fl;
    ovf_clr  = clr;
    @(posedge clk);
    if (fl) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      do_pop = (q.size() > 0) && rdy;
      drop   = wr && (q.size() == DEPTH) && !do_pop;
      if (do_pop) void'(q.pop_front());
      if (wr && !drop) q.push_back(d);
      m_ovf = drop || (m_ovf && !clr);
    end
    #1;
    wr_en    = 1'b0;
    rd_ready = 1'b0;
    flush    = 1'b0;
    ovf_clr  = 1'b0;
    check_all();
  endtask

  initial begin
    bit wr;
    bit rdy;
    int k;

    #1 rst_n = 1'b0;
    #2 check_all();
    #9 rst_n = 1'b1;

    phase = "single";
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    phase = "fill";
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    phase = "drain";
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    phase = "ovf";
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    phase = "ovf_set_vs_clr";
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    phase = "full_push_pop";
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    phase = "random";
    for (int i = 0; i < 40; i++) begin
      k   = i % 5;
      wr  = (k < 3);
      rdy = (k >= 3) || ($urandom_range(0, 3) == 0) || (q.size() >= DEPTH - 1);
      step(wr, 8'($urandom), rdy, 1'b0, 1'b0);
    end
    while (q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    phase = "flush";
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("count5", 32'(count), 32'd5);
    step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    phase = "empty_push_pop";
    step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);

    phase = "async_rst";
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    check_all();
    #2 rst_n = 1'b1;
    phase = "post_rst";
    step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
